data_selector_pipe: RTL
=======================

DATA_SELECTOR_PIPE -- requirements
Module: data_selector_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL be the width of one selectable element.
REQ-002 Parameter MAIN_INPUTS, default 16, SHALL be the element count of wData.
REQ-003 Parameter REGS_INPUTS, default 64, SHALL be the element count of wRegs.
REQ-004 Parameter LANES, default 4, SHALL be the output lane count.
REQ-005 Derived SRC_W = clog2(MAIN_INPUTS+REGS_INPUTS) (7 at defaults) SHALL be the source-index width; LANE_W = clog2(LANES) (min 1) SHALL be the lane-index width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wData  in  MAIN_INPUTS*DATA_WIDTH  main source elements; element i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 wRegs  in  REGS_INPUTS*DATA_WIDTH  register-file source elements, same packing.
REQ-010 in_valid / in_ready  in / out  1 each  input-beat handshake; beat accepted when both high.
REQ-011 cfg_we, cfg_lane, cfg_src, cfg_en  in  1, LANE_W, SRC_W, 1  shadow config write port.
REQ-012 cfg_commit  in  1  request to copy shadow config into active config.
REQ-013 data_out / out_valid / out_ready  out / out / in  LANES*DATA_WIDTH, 1, 1  output beat and handshake.
REQ-014 busy  out  1  high while a commit is in progress.
REQ-015 beat_cnt  out  16  count of accepted input beats.

Function
REQ-016 Per lane L the active config SHALL hold src[L] (SRC_W) and en[L]; the shadow config SHALL hold the same fields.
REQ-017 Selection: src < MAIN_INPUTS -> wData element src; MAIN_INPUTS <= src < MAIN_INPUTS+REGS_INPUTS -> wRegs element (src-MAIN_INPUTS); src out of range or en[L]=0 -> zero.
REQ-018 Lane L SHALL occupy data_out[L*DATA_WIDTH +: DATA_WIDTH].
REQ-019 On an accepted beat, data_out SHALL load the selection computed from that cycle's wData/wRegs and active config, and out_valid SHALL be high the next cycle (latency 1).
REQ-020 in_ready = (state==IDLE) && (!out_valid || out_ready); a beat SHALL be accepted in the same cycle the previous output is consumed (full throughput).
REQ-021 out_valid SHALL clear after out_valid&&out_ready when no new beat is accepted that cycle; data_out SHALL hold stable while out_valid && !out_ready.
REQ-022 cfg_we SHALL write shadow[cfg_lane] in any state; cfg_lane >= LANES SHALL be ignored.
REQ-023 FSM states IDLE, DRAIN, SWAP.
REQ-024 IDLE + cfg_commit: -> DRAIN if out_valid && !out_ready, else -> SWAP; a beat accepted in that same cycle SHALL use the old active config.
REQ-025 DRAIN: in_ready=0; -> SWAP in the cycle out_valid&&out_ready.
REQ-026 SWAP: active <= shadow (including a cfg_we in that same cycle, write-through), in_ready=0; -> IDLE next cycle.
REQ-027 busy SHALL be high in DRAIN and SWAP; cfg_commit outside IDLE SHALL be ignored.
REQ-028 beat_cnt SHALL increment by 1 per accepted beat, wrapping 16'hFFFF -> 0.

Reset
REQ-029 rst SHALL force: state IDLE, out_valid 0, data_out 0, busy 0, beat_cnt 0, all active and shadow src=0/en=0; rst SHALL take priority over all inputs, including mid-DRAIN/SWAP (commit discarded).

Verification
REQ-030 Reset, no config, in_valid=1, wData=64'h0123456789abcdef, out_ready=1 -> data_out=16'h0000 one cycle after acceptance, out_valid=1.
REQ-031 Shadow lanes 0..3 = src 0,1,16,79 en=1, commit, wRegs element0=4'h5, element63=4'h7, same wData -> after busy falls, data_out=16'h75ef.
REQ-032 out_ready=0 with out_valid=1 for 5 cycles -> data_out stable, in_ready=0, beat_cnt unchanged; out_ready=1 -> back-to-back beats, one per cycle.
REQ-033 Commit while out_valid && !out_ready -> busy=1, state DRAIN until out_ready, then one SWAP cycle, busy=0, next beat uses new config.
REQ-034 src=100 en=1 on lane 2 -> lane 2 = 4'h0; en=0 with valid src -> 4'h0.
REQ-035 Preload beat_cnt to 16'hFFFE via 65534 beats, two more beats -> 16'h0000; rst asserted during DRAIN -> all outputs at reset values next cycle, active config zero.

Source files
------------

// File: rtl/data_selector_pipe.sv
// Configurable per-lane element selector with a one-deep output register,
// shadow/active lane configuration and a drain-then-swap commit FSM.

module data_selector_lane #(
  parameter int DW    = 4,
  parameter int TOTAL = 80,
  parameter int SRC_W = 7
) (
  input  logic [TOTAL-1:0][DW-1:0] elems_i,
  input  logic [SRC_W-1:0]         src_i,
  input  logic                     en_i,
  output logic [DW-1:0]            data_o
);
  localparam logic [SRC_W:0] TOTAL_W = (SRC_W+1)'(TOTAL);

  always_comb begin
    data_o = '0;
    if (en_i && ({1'b0, src_i} < TOTAL_W)) data_o = elems_i[src_i];
  end
endmodule

module data_selector_pipe #(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int LANES       = 4,
  localparam int TOTAL      = MAIN_INPUTS + REGS_INPUTS,
  localparam int SRC_W      = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0] wData,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0] wRegs,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              cfg_we,
  input  logic [LANE_W-1:0]                 cfg_lane,
  input  logic [SRC_W-1:0]                  cfg_src,
  input  logic                              cfg_en,
  input  logic                              cfg_commit,
  output logic [LANES*DATA_WIDTH-1:0]       data_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [15:0]                       beat_cnt
);
  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;

  state_e                              state_q;
  logic                                out_valid_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]    data_q;
  logic [15:0]                         beat_cnt_q;
  logic [LANES-1:0][SRC_W-1:0]         act_src_q, shd_src_q, shd_src_d;
  logic [LANES-1:0]                    act_en_q, shd_en_q, shd_en_d;

  logic [TOTAL-1:0][DATA_WIDTH-1:0]    elems;
  logic [LANES-1:0][DATA_WIDTH-1:0]    sel;
  logic                                accept;

  // wData occupies the low element indices, wRegs follows.
  assign elems = {wRegs, wData};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    data_selector_lane #(
      .DW   (DATA_WIDTH),
      .TOTAL(TOTAL),
      .SRC_W(SRC_W)
    ) u_lane (
      .elems_i(elems),
      .src_i  (act_src_q[g]),
      .en_i   (act_en_q[g]),
      .data_o (sel[g])
    );
  end

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign beat_cnt  = beat_cnt_q;

  // Lanes beyond LANES never match, so out-of-range writes drop out here.
  always_comb begin
    shd_src_d = shd_src_q;
    shd_en_d  = shd_en_q;
    for (int l = 0; l < LANES; l++) begin
      if (cfg_we && (cfg_lane == LANE_W'(l))) begin
        shd_src_d[l] = cfg_src;
        shd_en_d[l]  = cfg_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      beat_cnt_q  <= '0;
      act_src_q   <= '0;
      act_en_q    <= '0;
      shd_src_q   <= '0;
      shd_en_q    <= '0;
    end else begin
      shd_src_q <= shd_src_d;
      shd_en_q  <= shd_en_d;

      if (accept) begin
        data_q      <= sel;
        out_valid_q <= 1'b1;
        beat_cnt_q  <= beat_cnt_q + 16'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE:  if (cfg_commit) state_q <= (out_valid_q && !out_ready) ? DRAIN : SWAP;
        DRAIN: if (out_valid_q && out_ready) state_q <= SWAP;
        SWAP: begin
          // Write-through: a config write landing this cycle is picked up too.
          act_src_q <= shd_src_d;
          act_en_q  <= shd_en_d;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
